// File: rtl/gearbox_fifo_pkg.sv
// Shared widths, lane helpers and parameter sanity checks
// for the pixel gearbox FIFO.
package gearbox_fifo_pkg;

  localparam int LANE_MAX_W = 64;
  localparam int BUS_MAX_W  = 1024;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int wc_width(input int in_lanes);
    return $clog2(in_lanes + 1);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit depth_ok(
    input int depth,
    input int in_lanes,
    input int out_lanes
  );
    return depth >= (in_lanes + out_lanes);
  endfunction

  function automatic bit bus_ok(
    input int dw,
    input int lanes
  );
    return (dw <= LANE_MAX_W) && (dw * lanes <= BUS_MAX_W);
  endfunction

  function automatic logic [LANE_MAX_W-1:0] lane_mask(input int dw);
    logic [LANE_MAX_W-1:0] m;
    if (dw >= LANE_MAX_W) m = '1;
    else m = (LANE_MAX_W'(1) << dw) - LANE_MAX_W'(1);
    return m;
  endfunction

  // Lane 0 sits in the LSBs of the packed bus.
  function automatic logic [LANE_MAX_W-1:0] lane_get(
    input logic [BUS_MAX_W-1:0] bus,
    input int                   lane,
    input int                   dw
  );
    logic [BUS_MAX_W-1:0] sh;
    sh = bus >> (lane * dw);
    return sh[LANE_MAX_W-1:0] & lane_mask(dw);
  endfunction

endpackage

// File: rtl/gearbox_fifo_mem.sv
// Element register array: IN_LANES write lanes at base+lane,
// OUT_LANES combinational read lanes at base+slot.
module gearbox_fifo_mem
  import gearbox_fifo_pkg::*;
#(
  parameter int DW        = 8,
  parameter int IN_LANES  = 3,
  parameter int OUT_LANES = 2,
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = 6
) (
  input  logic                    clk,
  input  logic [IN_LANES-1:0]     we,
  input  logic [ADDR_W-1:0]       wr_base,
  input  logic [DW*IN_LANES-1:0]  wr_data,
  input  logic [ADDR_W-1:0]       rd_base,
  output logic [DW*OUT_LANES-1:0] rd_data
);

  logic [DW-1:0] mem_q [DEPTH];

  // Write lane j carries bus lane IN_LANES-1-j (oldest first).
  always_ff @(posedge clk) begin
    for (int j = 0; j < IN_LANES; j++) begin
      if (we[j]) begin
        mem_q[wr_base + ADDR_W'(j)] <=
          DW'(lane_get(BUS_MAX_W'(wr_data), IN_LANES - 1 - j, DW));
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < OUT_LANES; k++) begin
      rd_data[(OUT_LANES-1-k)*DW +: DW] = mem_q[rd_base + ADDR_W'(k)];
    end
  end

endmodule

// File: rtl/gearbox_sync_fifo.sv
// Width-converting element FIFO: 0..IN_LANES pixels in per beat,
// OUT_LANES pixels out show-ahead.
module gearbox_sync_fifo
  import gearbox_fifo_pkg::*;
#(
  parameter int DW         = 8,
  parameter int IN_LANES   = 3,
  parameter int OUT_LANES  = 2,
  parameter int FIFO_DEPTH = 64,
  parameter int CNT_W      = cnt_width(FIFO_DEPTH),
  parameter int WC_W       = wc_width(IN_LANES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    wr_valid,
  input  logic [WC_W-1:0]         wr_cnt,
  input  logic [DW*IN_LANES-1:0]  wr_data,
  output logic                    wr_ready,
  input  logic                    rd_en,
  output logic [DW*OUT_LANES-1:0] rd_data,
  output logic                    rd_valid,
  output logic                    full,
  output logic                    empty,
  output logic [CNT_W-1:0]        fill_level,
  output logic                    wr_err,
  output logic                    rd_err
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W:0] DEPTH_X = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W:0] IN_X    = (CNT_W+1)'(IN_LANES);
  localparam logic [CNT_W:0] OUT_X   = (CNT_W+1)'(OUT_LANES);

  if (!is_pow2(FIFO_DEPTH)) begin : g_bad_depth_pow2
    $error("FIFO_DEPTH must be a power of two");
  end
  if (!depth_ok(FIFO_DEPTH, IN_LANES, OUT_LANES)) begin : g_bad_depth_min
    $error("FIFO_DEPTH must be >= IN_LANES+OUT_LANES");
  end
  if (!bus_ok(DW, IN_LANES)) begin : g_bad_bus
    $error("DW*IN_LANES exceeds lane helper range");
  end

  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    fill_q, fill_d;
  logic                wr_err_q, wr_err_d;
  logic                rd_err_q, rd_err_d;
  logic [CNT_W:0]      free_x;
  logic [CNT_W:0]      fill_x;
  logic                cnt_ok;
  logic                wr_fire;
  logic                rd_fire;
  logic [IN_LANES-1:0] lane_we;

  // Status comes from registered occupancy only.
  assign free_x     = DEPTH_X - {1'b0, fill_q};
  assign wr_ready   = free_x >= IN_X;
  assign rd_valid   = {1'b0, fill_q} >= OUT_X;
  assign full       = {1'b0, fill_q} == DEPTH_X;
  assign empty      = fill_q == '0;
  assign fill_level = fill_q;
  assign wr_err     = wr_err_q;
  assign rd_err     = rd_err_q;

  assign cnt_ok  = (wr_cnt != '0) && (int'(wr_cnt) <= IN_LANES);
  assign wr_fire = wr_valid && wr_ready && cnt_ok && !clr;
  assign rd_fire = rd_en && rd_valid && !clr;

  always_comb begin
    lane_we = '0;
    for (int j = 0; j < IN_LANES; j++) begin
      lane_we[j] = wr_fire && (int'(wr_cnt) > j);
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_x   = {1'b0, fill_q};
    wr_err_d = 1'b0;
    rd_err_d = 1'b0;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_x   = '0;
    end else begin
      if (wr_fire) begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(wr_cnt);
        fill_x   = fill_x + (CNT_W+1)'(wr_cnt);
      end
      if (rd_fire) begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(OUT_LANES);
        fill_x   = fill_x - OUT_X;
      end
      wr_err_d = wr_valid && !cnt_ok;
      rd_err_d = rd_en && !rd_valid;
    end
    fill_d = fill_x[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      wr_err_q <= wr_err_d;
      rd_err_q <= rd_err_d;
    end
  end

  gearbox_fifo_mem #(
    .DW        (DW),
    .IN_LANES  (IN_LANES),
    .OUT_LANES (OUT_LANES),
    .DEPTH     (FIFO_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we      (lane_we),
    .wr_base (wr_ptr_q),
    .wr_data (wr_data),
    .rd_base (rd_ptr_q),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_gearbox_sync_fifo.sv
// Scoreboard bench for gearbox_sync_fifo: element-queue reference
// model, randomized data and traffic.
module tb_gearbox_sync_fifo;

  localparam int DW    = 8;
  localparam int IL    = 3;
  localparam int OL    = 2;
  localparam int D     = 64;
  localparam int CNT_W = 7;
  localparam int WC_W  = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 clr = 1'b0;
  logic                 wr_valid = 1'b0;
  logic [WC_W-1:0]      wr_cnt = '0;
  logic [DW*IL-1:0]     wr_data = '0;
  logic                 wr_ready;
  logic                 rd_en = 1'b0;
  logic [DW*OL-1:0]     rd_data;
  logic                 rd_valid;
  logic                 full;
  logic                 empty;
  logic [CNT_W-1:0]     fill_level;
  logic                 wr_err;
  logic                 rd_err;

  always #5 clk = ~clk;

  gearbox_sync_fifo #(
    .DW(DW), .IN_LANES(IL), .OUT_LANES(OL), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .wr_valid(wr_valid), .wr_cnt(wr_cnt), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .full(full), .empty(empty),
    .fill_level(fill_level), .wr_err(wr_err), .rd_err(rd_err)
  );

  int checks = 0;
  int failures = 0;

  logic [DW-1:0]    mdl[$];
  logic [DW*OL-1:0] sb[$];

  int st_fill;
  bit st_valid, st_ready, st_full, st_empty;
  bit st_wr_err, st_rd_err, st_armed;
  bit pend_wr = 0, pend_rd = 0, armed = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: the FIFO is a queue of elements; state before the edge
  // decides acceptance, pops and error pulses.
  task automatic model_step();
    int n;
    st_fill   = mdl.size();
    st_valid  = st_fill >= OL;
    st_ready  = (D - st_fill) >= IL;
    st_full   = st_fill == D;
    st_empty  = st_fill == 0;
    st_wr_err = pend_wr;
    st_rd_err = pend_rd;
    st_armed  = armed;
    n = int'(wr_cnt);
    if (rst || clr) begin
      mdl.delete();
      pend_wr = 0;
      pend_rd = 0;
      if (rst) armed = 1;
    end else begin
      pend_wr = wr_valid && (n == 0 || n > IL);
      pend_rd = rd_en && !st_valid;
      if (rd_en && st_valid) begin
        sb.push_back({mdl[0], mdl[1]});
        void'(mdl.pop_front());
        void'(mdl.pop_front());
      end
      if (wr_valid && n >= 1 && n <= IL && st_ready)
        for (int i = 0; i < n; i++)
          mdl.push_back(wr_data[(IL-1-i)*DW +: DW]);
    end
  endtask

  task automatic cyc(bit r, bit c, bit wv, int wc, bit re);
    @(negedge clk);
    rst      = r;
    clr      = c;
    wr_valid = wv;
    wr_cnt   = WC_W'(wc);
    wr_data  = (DW*IL)'($urandom());
    rd_en    = re;
    #3;
    model_step();
  endtask

  task automatic idle();  cyc(0, 0, 0, 0, 0); endtask
  task automatic wr(int c); cyc(0, 0, 1, c, 0); endtask
  task automatic rd();    cyc(0, 0, 0, 0, 1); endtask

  task automatic drain();
    while (mdl.size() >= OL) rd();
  endtask

  task automatic wr_elems(int total, bit rand_rd);
    int left, c;
    left = total;
    while (left > 0) begin
      c = $urandom_range(1, IL);
      if (c > left) c = left;
      if ((D - mdl.size()) >= IL) begin
        cyc(0, 0, 1, c, rand_rd && ($urandom_range(0, 1) == 1));
        left -= c;
      end else begin
        rd();
      end
    end
  endtask

  // Monitor: compares status every cycle and pops the scoreboard
  // whenever the DUT presents a read.
  initial begin
    logic [DW*OL-1:0] exp_pair;
    forever begin
      @(negedge clk);
      #4;
      if (st_armed) begin
        chk("fill_level", 32'(fill_level), 32'(st_fill));
        chk("rd_valid", 32'(rd_valid), 32'(st_valid));
        chk("wr_ready", 32'(wr_ready), 32'(st_ready));
        chk("full", 32'(full), 32'(st_full));
        chk("empty", 32'(empty), 32'(st_empty));
        chk("wr_err", 32'(wr_err), 32'(st_wr_err));
        chk("rd_err", 32'(rd_err), 32'(st_rd_err));
        if (rd_en && rd_valid && !rst && !clr) begin
          if (sb.size() == 0) begin
            chk("rd_unexpected", 32'(1), 32'(0));
          end else begin
            exp_pair = sb.pop_front();
            chk("rd_data", 32'(rd_data), 32'(exp_pair));
          end
        end
      end
    end
  end

  initial begin
    int r;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    idle();
    chk("reset_empty", 32'(empty), 32'(1));
    chk("reset_wr_ready", 32'(wr_ready), 32'(1));
    chk("reset_fill", 32'(fill_level), 32'(0));

    // Mixed-width order
    wr(3); wr(1); wr(2); idle();
    chk("mixed_fill6", 32'(fill_level), 32'(6));
    rd(); rd(); rd(); idle();
    chk("mixed_fill0", 32'(fill_level), 32'(0));

    // Fill and backpressure
    for (int i = 0; i < 21; i++) wr(3);
    idle();
    chk("fill63", 32'(fill_level), 32'(63));
    chk("fill63_not_ready", 32'(wr_ready), 32'(0));
    cyc(0, 0, 1, 3, 1);
    idle();
    chk("after_pop_fill61", 32'(fill_level), 32'(61));
    chk("after_pop_ready", 32'(wr_ready), 32'(1));
    wr(3); idle();
    chk("full64", 32'(full), 32'(1));
    drain();

    // Wrap-around
    wr_elems(40, 0);
    drain();
    wr_elems(30, 1);
    drain();
    idle();
    chk("wrap_fill0", 32'(fill_level), 32'(0));

    // Simultaneous read/write at fill 5
    wr(3); wr(2);
    cyc(0, 0, 1, 2, 1);
    idle();
    chk("simul_fill5", 32'(fill_level), 32'(5));
    rd(); rd();
    rd(); idle();
    chk("rd_err_pulse", 32'(rd_err), 32'(1));
    chk("rd_err_nopop", 32'(fill_level), 32'(1));

    // Illegal write count
    cyc(0, 0, 1, 0, 0); idle();
    chk("wr_err_pulse", 32'(wr_err), 32'(1));
    chk("wr_err_fill", 32'(fill_level), 32'(1));

    // Clear at fill 17
    for (int i = 0; i < 5; i++) wr(3);
    wr(1); idle();
    chk("pre_clr_fill17", 32'(fill_level), 32'(17));
    cyc(0, 1, 1, 3, 1); idle();
    chk("clr_fill0", 32'(fill_level), 32'(0));
    chk("clr_empty", 32'(empty), 32'(1));

    // Reset mid-burst
    wr(3); wr(2); cyc(0, 0, 1, 3, 1);
    cyc(1, 0, 1, 3, 1); idle();
    chk("midrst_fill0", 32'(fill_level), 32'(0));
    chk("midrst_ready", 32'(wr_ready), 32'(1));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 999);
      cyc(r < 2, (r >= 2 && r < 12),
          $urandom_range(0, 9) < 7,
          ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, IL),
          $urandom_range(0, 1) == 1);
    end
    drain();
    idle(); idle();
    chk("scoreboard_drained", 32'(sb.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
